// File: rtl/pipe_hazard_ctrl.sv
// Stall, bubble and flush controller for the five-stage pipeline.
// Also sequences the iterative divider held in the execute stage.
module pipe_hazard_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_WD     = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ds_valid,
    input  logic [4:0] ds_rf_raddr1,
    input  logic [4:0] ds_rf_raddr2,
    input  logic       ds_src1_used,
    input  logic       ds_src2_used,
    input  logic       es_valid,
    input  logic [4:0] es_dest,
    input  logic       es_reg_we,
    input  logic       es_res_from_mem,
    input  logic       es_div_req,
    input  logic       br_taken,
    input  logic       ms_stall,
    input  logic       ex_flush,
    output logic       fs_stall,
    output logic       ds_stall,
    output logic       es_stall,
    output logic       es_bubble,
    output logic       fs_flush,
    output logic       ds_flush,
    output logic       es_flush,
    output logic       ms_flush,
    output logic       div_start,
    output logic       div_step,
    output logic       div_done,
    output logic       div_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_WD-1:0] LAST = CNT_WD'(DIV_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_WD-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;

    logic load_use;
    logic div_hold;
    logic br_kill;
    logic es_hold;
    logic act;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (ex_flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (es_valid && es_div_req) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end
                end
                S_RUN: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (!ms_stall) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign load_use = ds_valid & es_valid & es_res_from_mem & es_reg_we
                    & (es_dest != 5'd0)
                    & ((ds_src1_used & (es_dest == ds_rf_raddr1))
                     | (ds_src2_used & (es_dest == ds_rf_raddr2)));

    assign div_hold = es_valid & es_div_req & (state_q != S_DONE);
    assign es_hold  = div_hold | ms_stall;

    // A divide owns execute, so a coincident branch is ignored while it holds.
    assign br_kill = es_valid & br_taken & ~div_hold;

    // Reset and exception flush silence every stall, bubble and divider pulse.
    assign act = ~reset & ~ex_flush;

    assign es_stall  = act & es_hold;
    assign ds_stall  = act & (es_hold | (load_use & ~br_kill));
    assign fs_stall  = ds_stall;
    assign es_bubble = act & load_use & ~br_kill & ~es_hold;

    assign fs_flush = ~reset & (ex_flush | br_kill);
    assign ds_flush = fs_flush;
    assign es_flush = ~reset & ex_flush;
    assign ms_flush = es_flush;

    assign div_start = act & (state_q == S_IDLE) & es_valid & es_div_req;
    assign div_step  = act & (state_q == S_RUN);
    assign div_done  = act & (state_q == S_DONE);
    assign div_busy  = busy_q;

endmodule
